// File: rtl/dual_issue_ctrl_pkg.sv
// Shared types and constants for the dual-issue control stage.
package dual_issue_ctrl_pkg;

  typedef enum logic [0:0] {
    StPair,
    StSecond
  } issue_state_e;

  localparam int unsigned REG_ZERO      = 0;
  localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/dual_issue_ctrl_reg_match.sv
// Load-use match of one source register against the two ID_EX load destinations.
module dual_issue_ctrl_reg_match
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5
) (
  input  logic [REG_W-1:0] src,
  input  logic [REG_W-1:0] ex_dest_1,
  input  logic [REG_W-1:0] ex_dest_2,
  input  logic             ex_mem_rd_1,
  input  logic             ex_mem_rd_2,
  output logic             hit
);

  // Register 0 is hardwired, so it never creates a load-use hazard.
  assign hit = (src != REG_W'(REG_ZERO)) &&
               ((ex_mem_rd_1 && (src == ex_dest_1)) || (ex_mem_rd_2 && (src == ex_dest_2)));

endmodule

// File: rtl/dual_issue_ctrl.sv
// Issue control between IF_ID and ID_EX: pair issue, split over two cycles, or stall.
module dual_issue_ctrl
  import dual_issue_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = 5,
  parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             pair_valid,
  input  logic [REG_W-1:0] rs_1,
  input  logic [REG_W-1:0] rt_1,
  input  logic [REG_W-1:0] dest_1,
  input  logic             wr_en_1,
  input  logic             mem_op_1,
  input  logic [REG_W-1:0] rs_2,
  input  logic [REG_W-1:0] rt_2,
  input  logic [REG_W-1:0] dest_2,
  input  logic             wr_en_2,
  input  logic             mem_op_2,
  input  logic [REG_W-1:0] ex_dest_1,
  input  logic [REG_W-1:0] ex_dest_2,
  input  logic             ex_mem_rd_1,
  input  logic             ex_mem_rd_2,
  output logic             issue_1,
  output logic             issue_2,
  output logic             if_id_hold,
  output logic             split_pending,
  output logic [CNT_W-1:0] cnt_pair,
  output logic [CNT_W-1:0] cnt_split,
  output logic [CNT_W-1:0] cnt_stall
);

  issue_state_e state_q, state_d;
  logic lu_rs_1, lu_rt_1, lu_rs_2, lu_rt_2;
  logic lu_1, lu_2, raw21, waw, mem2, conflict;
  logic inc_pair, inc_split, inc_stall;
  logic [CNT_W-1:0] cnt_pair_q, cnt_pair_d, cnt_split_q, cnt_split_d, cnt_stall_q, cnt_stall_d;

  dual_issue_ctrl_reg_match #(.REG_W(REG_W)) u_lu_rs_1 (
    .src(rs_1), .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2), .hit(lu_rs_1)
  );
  dual_issue_ctrl_reg_match #(.REG_W(REG_W)) u_lu_rt_1 (
    .src(rt_1), .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2), .hit(lu_rt_1)
  );
  dual_issue_ctrl_reg_match #(.REG_W(REG_W)) u_lu_rs_2 (
    .src(rs_2), .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2), .hit(lu_rs_2)
  );
  dual_issue_ctrl_reg_match #(.REG_W(REG_W)) u_lu_rt_2 (
    .src(rt_2), .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2), .hit(lu_rt_2)
  );

  assign lu_1     = lu_rs_1 | lu_rt_1;
  assign lu_2     = lu_rs_2 | lu_rt_2;
  assign raw21    = wr_en_1 && (dest_1 != REG_W'(REG_ZERO)) &&
                    ((dest_1 == rs_2) || (dest_1 == rt_2));
  assign waw      = wr_en_1 && wr_en_2 && (dest_1 != REG_W'(REG_ZERO)) && (dest_1 == dest_2);
  // Single data-memory port: two memory ops cannot issue together.
  assign mem2     = mem_op_1 & mem_op_2;
  assign conflict = raw21 | waw | mem2;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StPair;
      cnt_pair_q  <= '0;
      cnt_split_q <= '0;
      cnt_stall_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_pair_q  <= cnt_pair_d;
      cnt_split_q <= cnt_split_d;
      cnt_stall_q <= cnt_stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = StPair;
    end else begin
      unique case (state_q)
        StPair:   if (pair_valid && !lu_1 && (conflict || lu_2)) state_d = StSecond;
        StSecond: if (!lu_2) state_d = StPair;
        default:  state_d = StPair;
      endcase
    end
  end

  always_comb begin
    issue_1    = 1'b0;
    issue_2    = 1'b0;
    if_id_hold = 1'b0;
    inc_pair   = 1'b0;
    inc_split  = 1'b0;
    inc_stall  = 1'b0;
    if (!reset && !flush) begin
      unique case (state_q)
        StPair: begin
          if (pair_valid) begin
            if (lu_1) begin
              if_id_hold = 1'b1;
              inc_stall  = 1'b1;
            end else if (conflict || lu_2) begin
              issue_1    = 1'b1;
              if_id_hold = 1'b1;
              inc_split  = 1'b1;
            end else begin
              issue_1  = 1'b1;
              issue_2  = 1'b1;
              inc_pair = 1'b1;
            end
          end
        end
        StSecond: begin
          // IF_ID is frozen here, so pair_valid is irrelevant.
          if (lu_2) begin
            if_id_hold = 1'b1;
            inc_stall  = 1'b1;
          end else begin
            issue_2 = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    cnt_pair_d  = cnt_pair_q;
    cnt_split_d = cnt_split_q;
    cnt_stall_d = cnt_stall_q;
    if (inc_pair && (cnt_pair_q != '1))   cnt_pair_d  = cnt_pair_q + CNT_W'(1);
    if (inc_split && (cnt_split_q != '1)) cnt_split_d = cnt_split_q + CNT_W'(1);
    if (inc_stall && (cnt_stall_q != '1)) cnt_stall_d = cnt_stall_q + CNT_W'(1);
  end

  assign split_pending = (state_q == StSecond) && !reset;
  assign cnt_pair      = cnt_pair_q;
  assign cnt_split     = cnt_split_q;
  assign cnt_stall     = cnt_stall_q;

endmodule

// File: tb/tb_dual_issue_ctrl.sv
// Scoreboard bench for dual_issue_ctrl: directed vectors, monitor compares at negedge.
module tb_dual_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset, flush, pair_valid;
  logic [4:0] rs_1, rt_1, dest_1, rs_2, rt_2, dest_2, ex_dest_1, ex_dest_2;
  logic       wr_en_1, mem_op_1, wr_en_2, mem_op_2, ex_mem_rd_1, ex_mem_rd_2;
  logic       issue_1, issue_2, if_id_hold, split_pending;
  logic [15:0] cnt_pair, cnt_split, cnt_stall;
  logic       s_issue_1, s_issue_2, s_hold, s_split_pending;
  logic [3:0] s_cnt_pair, s_cnt_split, s_cnt_stall;

  typedef struct packed {
    logic        i1;
    logic        i2;
    logic        hold;
    logic        sp;
    logic [15:0] cp;
    logic [15:0] cs;
    logic [15:0] cst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dual_issue_ctrl #(.REG_W(5), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .flush(flush), .pair_valid(pair_valid),
    .rs_1(rs_1), .rt_1(rt_1), .dest_1(dest_1), .wr_en_1(wr_en_1), .mem_op_1(mem_op_1),
    .rs_2(rs_2), .rt_2(rt_2), .dest_2(dest_2), .wr_en_2(wr_en_2), .mem_op_2(mem_op_2),
    .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2),
    .issue_1(issue_1), .issue_2(issue_2), .if_id_hold(if_id_hold),
    .split_pending(split_pending),
    .cnt_pair(cnt_pair), .cnt_split(cnt_split), .cnt_stall(cnt_stall)
  );

  // Narrow-counter copy so saturation is reachable in a short run.
  dual_issue_ctrl #(.REG_W(5), .CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .flush(flush), .pair_valid(pair_valid),
    .rs_1(rs_1), .rt_1(rt_1), .dest_1(dest_1), .wr_en_1(wr_en_1), .mem_op_1(mem_op_1),
    .rs_2(rs_2), .rt_2(rt_2), .dest_2(dest_2), .wr_en_2(wr_en_2), .mem_op_2(mem_op_2),
    .ex_dest_1(ex_dest_1), .ex_dest_2(ex_dest_2),
    .ex_mem_rd_1(ex_mem_rd_1), .ex_mem_rd_2(ex_mem_rd_2),
    .issue_1(s_issue_1), .issue_2(s_issue_2), .if_id_hold(s_hold),
    .split_pending(s_split_pending),
    .cnt_pair(s_cnt_pair), .cnt_split(s_cnt_split), .cnt_stall(s_cnt_stall)
  );

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a = '{issue_1, issue_2, if_id_hold, split_pending, cnt_pair, cnt_split, cnt_stall};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got i1=%b i2=%b hold=%b sp=%b cp=%0d cs=%0d cst=%0d want i1=%b i2=%b hold=%b sp=%b cp=%0d cs=%0d cst=%0d",
                 $time, a.i1, a.i2, a.hold, a.sp, a.cp, a.cs, a.cst,
                 e.i1, e.i2, e.hold, e.sp, e.cp, e.cs, e.cst);
      end
    end
  end

  task automatic set_pair(input logic [4:0] a_rs1, a_rt1, a_d1, input logic a_we1, a_m1,
                          input logic [4:0] a_rs2, a_rt2, a_d2, input logic a_we2, a_m2);
    pair_valid = 1'b1;
    rs_1 = a_rs1; rt_1 = a_rt1; dest_1 = a_d1; wr_en_1 = a_we1; mem_op_1 = a_m1;
    rs_2 = a_rs2; rt_2 = a_rt2; dest_2 = a_d2; wr_en_2 = a_we2; mem_op_2 = a_m2;
  endtask

  task automatic set_ex(input logic md1, input logic [4:0] ed1,
                        input logic md2, input logic [4:0] ed2);
    ex_mem_rd_1 = md1; ex_dest_1 = ed1; ex_mem_rd_2 = md2; ex_dest_2 = ed2;
  endtask

  // Push the expectation for the current cycle, then advance past the next edge.
  task automatic cyc(input logic i1, i2, h, sp, input int cp, cs, cst);
    exp_q.push_back('{i1, i2, h, sp, 16'(cp), 16'(cs), 16'(cst)});
    @(posedge clk);
    #1;
  endtask

  task automatic check_sat(input string name, input logic [3:0] got, input logic [3:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0;
    set_pair(1, 2, 3, 1, 0, 4, 5, 6, 1, 0);
    set_ex(0, 0, 0, 0);
    @(posedge clk); #1;
    // Reset cycle with a valid pair present: nothing issues.
    cyc(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;

    // Independent pair.
    cyc(1, 1, 0, 0, 0, 0, 0);
    // RAW lane1 -> lane2 splits.
    set_pair(1, 2, 3, 1, 0, 3, 5, 6, 1, 0);
    cyc(1, 0, 1, 0, 1, 0, 0);
    cyc(0, 1, 0, 1, 1, 1, 0);
    // Load-use on lane 1 stalls once.
    set_pair(7, 2, 3, 1, 0, 4, 5, 6, 1, 0);
    set_ex(1, 7, 0, 0);
    cyc(0, 0, 1, 0, 1, 1, 0);
    set_ex(0, 7, 0, 0);
    cyc(1, 1, 0, 0, 1, 1, 1);
    // lw $8 then a lane-2 use of $8: split, then one stall in SECOND.
    set_pair(1, 0, 8, 1, 1, 8, 5, 6, 1, 0);
    cyc(1, 0, 1, 0, 2, 1, 1);
    set_ex(1, 8, 0, 0);
    cyc(0, 0, 1, 1, 2, 2, 1);
    set_ex(0, 0, 0, 0);
    cyc(0, 1, 0, 1, 2, 2, 2);
    // Flush while in SECOND.
    set_pair(1, 2, 3, 1, 0, 3, 5, 6, 1, 0);
    cyc(1, 0, 1, 0, 2, 2, 2);
    flush = 1'b1;
    cyc(0, 0, 0, 1, 2, 3, 2);
    flush = 1'b0; pair_valid = 1'b0;
    cyc(0, 0, 0, 0, 2, 3, 2);
    // Register 0 never matches: RAW/WAW on $0 and load-use on $0.
    set_pair(1, 2, 0, 1, 0, 0, 0, 0, 1, 0);
    cyc(1, 1, 0, 0, 2, 3, 2);
    set_pair(0, 0, 3, 1, 0, 4, 5, 6, 1, 0);
    set_ex(1, 0, 1, 0);
    cyc(1, 1, 0, 0, 3, 3, 2);
    set_ex(0, 0, 0, 0);
    // Two memory ops split.
    set_pair(1, 2, 3, 1, 1, 4, 5, 6, 0, 1);
    cyc(1, 0, 1, 0, 4, 3, 2);
    cyc(0, 1, 0, 1, 4, 4, 2);
    // WAW splits.
    set_pair(1, 2, 9, 1, 0, 4, 5, 9, 1, 0);
    cyc(1, 0, 1, 0, 4, 4, 2);
    cyc(0, 1, 0, 1, 4, 5, 2);
    // In SECOND, pair_valid low still issues lane 2.
    cyc(1, 0, 1, 0, 4, 5, 2);
    pair_valid = 1'b0;
    cyc(0, 1, 0, 1, 4, 6, 2);
    // Flush coincident with an independent pair: no issue, no count.
    set_pair(1, 2, 3, 1, 0, 4, 5, 6, 1, 0);
    flush = 1'b1;
    cyc(0, 0, 0, 0, 4, 6, 2);
    flush = 1'b0; pair_valid = 1'b0;
    cyc(0, 0, 0, 0, 4, 6, 2);
    // Reset mid-SECOND abandons lane 2 and clears counters.
    set_pair(1, 2, 3, 1, 0, 3, 5, 6, 1, 0);
    cyc(1, 0, 1, 0, 4, 6, 2);
    reset = 1'b1;
    cyc(0, 0, 0, 0, 4, 7, 2);
    reset = 1'b0; pair_valid = 1'b0;
    cyc(0, 0, 0, 0, 0, 0, 0);
    // Continuous stalls: narrow copy saturates at 15.
    set_pair(7, 2, 3, 1, 0, 4, 5, 6, 1, 0);
    set_ex(0, 0, 1, 7);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, 0, 0, 0, i);
    check_sat("sat_stall_17", s_cnt_stall, 4'hF);
    cyc(0, 0, 1, 0, 0, 0, 17);
    check_sat("sat_stall_18", s_cnt_stall, 4'hF);
    check_sat("sat_pair_zero", s_cnt_pair, 4'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain got=%0d pending want=0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
